// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// registers the returned word into IF/ID, with redirect bubbles and a fetch counter.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        Stall,
  input  logic        Redirect_Br,
  input  logic        Redirect_J,
  input  logic [31:0] Redirect_Base,
  input  logic [15:0] Br_Imm,
  input  logic [25:0] J_Target,
  input  logic [31:0] Inst_In,
  output logic [31:0] Inst_Addr,
  output logic [31:0] IfId_Inst,
  output logic [31:0] IfId_Pc4,
  output logic        IfId_Valid,
  output logic [31:0] Fetch_Count
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] redirect_pc;
  logic        redirect;

  function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                input logic [15:0] imm);
    logic signed [31:0] offset;
    offset = {{14{imm[15]}}, imm, 2'b00};
    return base + offset;
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] base,
                                              input logic [25:0] target);
    return {base[31:28], target, 2'b00};
  endfunction

  assign pc4         = pc + 32'd4;
  assign redirect    = Redirect_J | Redirect_Br;
  // Jump outranks branch when both strobes arrive together.
  assign redirect_pc = Redirect_J ? jump_target(Redirect_Base, J_Target)
                                  : branch_target(Redirect_Base, Br_Imm);

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      pc          <= RESET_PC_ALIGNED;
      IfId_Inst   <= 32'h0;
      IfId_Pc4    <= 32'h0;
      IfId_Valid  <= 1'b0;
      Fetch_Count <= 32'h0;
    end else if (redirect) begin
      // The word fetched this cycle is squashed: bubble into IF/ID, no count.
      pc          <= redirect_pc;
      IfId_Inst   <= 32'h0;
      IfId_Pc4    <= 32'h0;
      IfId_Valid  <= 1'b0;
    end else if (!Stall) begin
      pc          <= pc4;
      IfId_Inst   <= Inst_In;
      IfId_Pc4    <= pc4;
      IfId_Valid  <= 1'b1;
      Fetch_Count <= Fetch_Count + 32'd1;
    end
  end

  assign Inst_Addr = pc;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction ROM.
- Holds the program counter and drives the ROM byte address.
- Captures the returned instruction into an IF/ID register for the decoder.
- Handles sequential fetch, stall, and branch/jump redirects with a one-cycle bubble, plus a delivered-instruction counter for debug and performance.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
Clk  input  1  rising-edge clock
Clrn  input  1  asynchronous active-low reset
Stall  input  1  hold PC and IF/ID contents this cycle
Redirect_Br  input  1  taken conditional branch (beq/bne) resolved downstream
Redirect_J  input  1  unconditional jump (j) resolved downstream
Redirect_Base  input  32  PC+4 of the redirecting instruction
Br_Imm  input  16  raw branch immediate, in words
J_Target  input  26  raw jump target field, in words
Inst_In  input  32  instruction word returned combinationally by the ROM for Inst_Addr
Inst_Addr  output  32  current PC, byte address to the ROM; the ROM indexes Addr[6:2]
IfId_Inst  output  32  registered instruction for decode
IfId_Pc4  output  32  registered PC+4 of IfId_Inst
IfId_Valid  output  1  IfId_Inst is a real fetched instruction
Fetch_Count  output  32  number of instructions delivered into IF/ID

Behaviour:
- Clrn low, asynchronous, any time including mid-operation:
  - PC=RESET_PC, IfId_Inst=32'h0 (nop), IfId_Pc4=0, IfId_Valid=0, Fetch_Count=0.
  - Normal operation resumes on the first rising Clk after Clrn is released.
- Inst_Addr = PC, combinational from the PC register; no added latency. The ROM is combinational, so Inst_In is sampled on the same edge.
- Target arithmetic:
  - Branch target = Redirect_Base + (sign_extend(Br_Imm) << 2), modulo 2^32.
  - Jump target = {Redirect_Base[31:28], J_Target, 2'b00}.
  - PC[1:0] is always 00.
- Per rising edge, in priority order:
  1. Redirect_J=1: PC <= jump target; IfId_Inst <= 0; IfId_Valid <= 0; IfId_Pc4 <= 0. Overrides Redirect_Br and Stall.
  2. Redirect_Br=1: PC <= branch target; bubble inserted identically to a jump. Overrides Stall.
  3. Stall=1: PC, IfId_*, and Fetch_Count all hold.
  4. Otherwise: PC <= PC+4; IfId_Inst <= Inst_In; IfId_Pc4 <= PC+4; IfId_Valid <= 1; Fetch_Count <= Fetch_Count+1.
- Wrap-around:
  - PC 32'hFFFF_FFFC + 4 gives 32'h0000_0000.
  - Fetch_Count wraps from 32'hFFFF_FFFF to 0.
  - Neither condition is flagged.
- Redirect inputs are only honored when their strobe is 1; Redirect_Base, Br_Imm, and J_Target are don't-care otherwise.
- The instruction fetched in the cycle a redirect is taken is discarded and not counted.
- An X on Inst_In (unpopulated ROM word) propagates into IfId_Inst unchanged. The stage performs no decode.
- State summary:
  - RUN: sequential fetch.
  - HOLD: Stall asserted.
  - BUBBLE: the cycle after a redirect, with IfId_Valid=0.
  - BUBBLE returns to RUN, or to HOLD if Stall is asserted, on the next edge without a redirect.

Test Plan:
- Reset then 1 clock with the ROM program loaded -> Inst_Addr=0x00 before the edge; after the edge: Inst_Addr=0x04, IfId_Inst=32'h3401000A, IfId_Pc4=0x04, IfId_Valid=1, Fetch_Count=1.
- Run to Inst_Addr=0x18 (j 0x0C), then assert Redirect_J with Redirect_Base=0x1C and J_Target=26'h00000C -> next Inst_Addr=0x30, IfId_Valid=0, Fetch_Count unchanged; the following edge delivers 32'h10220004 with IfId_Pc4=0x34.
- Redirect_Br with Redirect_Base=0x38 and Br_Imm=16'h0004 -> Inst_Addr=0x48, delivered word 32'h00A63820.
- Br_Imm=16'hFFFE with Redirect_Base=0x10 -> Inst_Addr=0x08.
- Stall held 3 cycles at Inst_Addr=0x08 -> PC, IfId_*, and Fetch_Count unchanged across all 3 cycles.
- Stall and Redirect_Br on the same edge -> redirect taken, bubble inserted.
- Redirect_Br and Redirect_J together with Redirect_Base=0x1C, J_Target=0x0C, Br_Imm=1 -> Inst_Addr=0x30 (jump wins).
- Async reset pulsed mid-cycle while PC=0x44 -> all outputs reset immediately without a clock edge, Inst_Addr=RESET_PC.
- Force PC to 0xFFFF_FFFC via a jump with Redirect_Base[31:28]=4'hF and J_Target=26'h3FFFFFF -> the next sequential edge gives Inst_Addr=0x0000_0000 and IfId_Pc4=0x0000_0000.
